atm_keypad_entry: RTL and testbench
===================================

# atm_keypad_entry

Upstream input stage of the ATM controller. Turns raw keypad strobes into the ATM's one-cycle command pulses (Submit, ShowBalance, Withdraw, Eject). Assembles a 4-bit PIN and a 5-bit withdrawal amount, held stable on Password/Value. Also handles card-removal and inactivity timeout.

## Interface
- TIMEOUT_CYCLES, 255: idle cycles allowed in PIN/MENU/AMT before forced eject; legal range 2..255.
- Clock  in  1  system clock; all logic on rising edge.
- Clear  in  1  synchronous, active-high reset.
- CardIn  in  1  card present level; synchronous to Clock.
- ErrPass  in  1  ATM's password-error flag, level.
- KeyStrobe  in  1  raw asynchronous key-pressed level.
- KeyCode  in  4  key code; 0–9 digit, A Enter, B Cancel, C Balance, D Withdraw, E Eject, F ignored.
- Password  out  5→4  PIN to ATM (4 bits), held until next Submit.
- Value  out  5  withdrawal amount to ATM, held until next Withdraw.
- Submit  out  1  one-cycle pulse; Password valid.
- ShowBalance  out  1  one-cycle pulse.
- Withdraw  out  1  one-cycle pulse; Value valid.
- Eject  out  1  one-cycle pulse.
- EntryErr  out  1  one-cycle pulse on rejected entry.
- EntryState  out  2  0 NOCARD, 1 PIN, 2 MENU, 3 AMT.

## Operation
- KeyStrobe passes through a two-flop synchroniser. A third flop feeds rising-edge detection, giving one key event per press.
- KeyCode is read at the key event. The keypad holds KeyCode stable for the whole KeyStrobe high time.
- Per-cycle priority: Clear > CardIn low > timeout > ErrPass > key event.
- NOCARD:
  - All keys ignored.
  - CardIn high → PIN; clear PIN buffer.
- PIN:
  - Digit → PinBuf=digit, PinHave=1; the last digit wins.
  - Enter with PinHave=1 → Password=PinBuf, Submit pulse, → MENU.
  - Enter with PinHave=0 → EntryErr pulse, stay in PIN.
  - Cancel → PinHave=0.
  - Eject → Eject pulse, → NOCARD.
  - Balance, Withdraw and F are ignored.
- MENU:
  - ErrPass high → PIN with PinHave=0; no pulse.
  - Balance → ShowBalance pulse.
  - Withdraw key → AMT; Acc=0, Cnt=0.
  - Eject → Eject pulse, → NOCARD.
  - Other keys are ignored.
- AMT:
  - Digit with Cnt<2 → Acc=Acc*10+digit (7-bit arithmetic), Cnt+1.
  - Digit with Cnt=2 → EntryErr pulse; Acc unchanged.
  - Enter with Cnt=0 or Acc>31 → EntryErr pulse; Acc=0, Cnt=0, stay in AMT.
  - Enter otherwise → Value=Acc[4:0], Withdraw pulse, → MENU.
  - Cancel → MENU, no pulse.
  - Eject → Eject pulse, → NOCARD.
  - Balance and F are ignored.
- CardIn low in any non-NOCARD state → NOCARD immediately. No Eject pulse; buffers cleared; Password and Value retained.
- Timeout counter:
  - Cleared on every state change and every key event, whether the key is accepted or ignored.
  - Increments in PIN/MENU/AMT and holds at 0 in NOCARD.
  - Reaching TIMEOUT_CYCLES-1 → Eject pulse, → NOCARD.
- At most one pulse output is high in any cycle.

## Timing
- Reset values: every output 0, EntryState=0, all internal buffers and counters 0.
- Key latency: KeyStrobe rise first sampled at edge n → key event at edge n+2 → registered pulse/state visible after edge n+2.
- KeyStrobe minimum 3 cycles high and 3 cycles low; a held key produces exactly one event.
- CardIn change at edge n → EntryState updated after edge n (single-cycle response, CardIn already synchronous).
- Timeout: with no events, Eject is high in the cycle after the TIMEOUT_CYCLES-th rising edge following state entry.
- Password and Value update in the same cycle their pulse is high, and are stable for ATM sampling on the following edge.
- Clear mid-entry → NOCARD on that edge; no pulse emitted.

## Test plan
- Reset: Clear high 2 cycles → all outputs 0, EntryState=0; strobe key 5 with CardIn=0 → no pulse, state 0.
- PIN: CardIn=1, keys 3, 7, Enter → Password=7, single Submit pulse 3 cycles after the Enter strobe, EntryState=2.
- Withdraw: in MENU press D, 2, 5, Enter → Value=25, one Withdraw pulse, EntryState=2. Then D, 3, 2, Enter → EntryErr pulse, Value still 25, EntryState=3. Then D, 4, 1, 9 → EntryErr on the third digit.
- ErrPass: ErrPass=1 in MENU → EntryState=1. Enter with no digit → EntryErr. Balance key in MENU → ShowBalance pulse.
- Timeout: TIMEOUT_CYCLES=16, enter PIN, no keys → Eject pulse after the 16th edge, EntryState=0. A key at cycle 10 restarts the count.
- Card pull: CardIn→0 in AMT with Acc=2 → EntryState=0 next edge, no Eject/Withdraw pulse. Re-insert → PIN with PinHave=0.

Source files
------------

// File: rtl/atm_keypad_entry.sv
// ATM keypad front end: turns raw key strobes into one-cycle ATM commands and
// assembles the PIN and withdrawal amount, with card-pull and inactivity eject.
module atm_keypad_entry #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic       Clock,
  input  logic       Clear,
  input  logic       CardIn,
  input  logic       ErrPass,
  input  logic       KeyStrobe,
  input  logic [3:0] KeyCode,
  output logic [3:0] Password,
  output logic [4:0] Value,
  output logic       Submit,
  output logic       ShowBalance,
  output logic       Withdraw,
  output logic       Eject,
  output logic       EntryErr,
  output logic [1:0] EntryState
);

  localparam int unsigned TCNT_W = 8;
  localparam int unsigned ACC_W  = 7;

  localparam logic [3:0] KEY_ENTER    = 4'hA;
  localparam logic [3:0] KEY_CANCEL   = 4'hB;
  localparam logic [3:0] KEY_BALANCE  = 4'hC;
  localparam logic [3:0] KEY_WITHDRAW = 4'hD;
  localparam logic [3:0] KEY_EJECT    = 4'hE;

  typedef enum logic [1:0] {NOCARD = 2'd0, PIN = 2'd1, MENU = 2'd2, AMT = 2'd3} state_t;

  state_t              state;
  logic                sync1, sync2, sync3;
  logic [3:0]          pin_buf;
  logic                pin_have;
  logic [ACC_W-1:0]    acc;
  logic [1:0]          cnt;
  logic [TCNT_W-1:0]   tcnt;
  logic                key_evt;
  logic                is_digit;
  logic                timed_out;

  assign key_evt    = sync2 & ~sync3;
  assign is_digit   = (KeyCode < 4'd10);
  assign timed_out  = (state != NOCARD) && (tcnt == TCNT_W'(TIMEOUT_CYCLES - 1));
  assign EntryState = state;

  // Strobe synchroniser plus edge-detect flop
  always_ff @(posedge Clock) begin
    if (Clear) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= KeyStrobe;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  always_ff @(posedge Clock) begin
    if (Clear) begin
      state       <= NOCARD;
      pin_buf     <= '0;
      pin_have    <= 1'b0;
      acc         <= '0;
      cnt         <= '0;
      tcnt        <= '0;
      Password    <= '0;
      Value       <= '0;
      Submit      <= 1'b0;
      ShowBalance <= 1'b0;
      Withdraw    <= 1'b0;
      Eject       <= 1'b0;
      EntryErr    <= 1'b0;
    end else begin
      Submit      <= 1'b0;
      ShowBalance <= 1'b0;
      Withdraw    <= 1'b0;
      Eject       <= 1'b0;
      EntryErr    <= 1'b0;
      // Idle count; every state change below also zeroes it
      tcnt <= (state == NOCARD) ? '0 : tcnt + TCNT_W'(1);
      if (key_evt) tcnt <= '0;

      if (state != NOCARD && !CardIn) begin
        state    <= NOCARD;
        pin_buf  <= '0;
        pin_have <= 1'b0;
        acc      <= '0;
        cnt      <= '0;
        tcnt     <= '0;
      end else if (timed_out) begin
        Eject <= 1'b1;
        state <= NOCARD;
        tcnt  <= '0;
      end else if (state == MENU && ErrPass) begin
        state    <= PIN;
        pin_have <= 1'b0;
        tcnt     <= '0;
      end else begin
        case (state)
          NOCARD: if (CardIn) begin
            state    <= PIN;
            pin_buf  <= '0;
            pin_have <= 1'b0;
            tcnt     <= '0;
          end
          PIN: if (key_evt) begin
            if (is_digit) begin
              pin_buf  <= KeyCode;
              pin_have <= 1'b1;
            end else if (KeyCode == KEY_ENTER) begin
              if (pin_have) begin
                Password <= pin_buf;
                Submit   <= 1'b1;
                state    <= MENU;
              end else begin
                EntryErr <= 1'b1;
              end
            end else if (KeyCode == KEY_CANCEL) begin
              pin_have <= 1'b0;
            end else if (KeyCode == KEY_EJECT) begin
              Eject <= 1'b1;
              state <= NOCARD;
            end
          end
          MENU: if (key_evt) begin
            if (KeyCode == KEY_BALANCE) begin
              ShowBalance <= 1'b1;
            end else if (KeyCode == KEY_WITHDRAW) begin
              state <= AMT;
              acc   <= '0;
              cnt   <= '0;
            end else if (KeyCode == KEY_EJECT) begin
              Eject <= 1'b1;
              state <= NOCARD;
            end
          end
          AMT: if (key_evt) begin
            if (is_digit) begin
              if (cnt < 2'd2) begin
                acc <= ACC_W'(acc * ACC_W'(10) + ACC_W'(KeyCode));
                cnt <= cnt + 2'd1;
              end else begin
                EntryErr <= 1'b1;
              end
            end else if (KeyCode == KEY_ENTER) begin
              if (cnt == 2'd0 || acc > ACC_W'(31)) begin
                EntryErr <= 1'b1;
                acc      <= '0;
                cnt      <= '0;
              end else begin
                Value    <= acc[4:0];
                Withdraw <= 1'b1;
                state    <= MENU;
              end
            end else if (KeyCode == KEY_CANCEL) begin
              state <= MENU;
            end else if (KeyCode == KEY_EJECT) begin
              Eject <= 1'b1;
              state <= NOCARD;
            end
          end
          default: state <= NOCARD;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_atm_keypad_entry.sv
// Directed bench for atm_keypad_entry: PIN, withdraw, balance, error, card-pull,
// clear and inactivity-timeout scenarios with hand-computed expectations.
module tb_atm_keypad_entry;

  logic       Clock = 1'b0;
  logic       Clear, CardIn, ErrPass, KeyStrobe;
  logic [3:0] KeyCode;
  logic [3:0] Password;
  logic [4:0] Value;
  logic       Submit, ShowBalance, Withdraw, Eject, EntryErr;
  logic [1:0] EntryState;

  int n_checks = 0;
  int n_fail   = 0;

  int n_sub = 0, n_bal = 0, n_wd = 0, n_ej = 0, n_err = 0, n_multi = 0;
  int b_sub, b_bal, b_wd, b_ej, b_err;

  atm_keypad_entry #(.TIMEOUT_CYCLES(16)) dut (
    .Clock(Clock), .Clear(Clear), .CardIn(CardIn), .ErrPass(ErrPass),
    .KeyStrobe(KeyStrobe), .KeyCode(KeyCode), .Password(Password), .Value(Value),
    .Submit(Submit), .ShowBalance(ShowBalance), .Withdraw(Withdraw), .Eject(Eject),
    .EntryErr(EntryErr), .EntryState(EntryState)
  );

  always #5 Clock = ~Clock;

  // Pulse tally, sampled mid-cycle
  always @(negedge Clock) begin
    n_sub <= n_sub + int'(Submit);
    n_bal <= n_bal + int'(ShowBalance);
    n_wd  <= n_wd  + int'(Withdraw);
    n_ej  <= n_ej  + int'(Eject);
    n_err <= n_err + int'(EntryErr);
    if (int'(Submit) + int'(ShowBalance) + int'(Withdraw) + int'(Eject) + int'(EntryErr) > 1)
      n_multi <= n_multi + 1;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge Clock);
    #1;
  endtask

  task automatic snap();
    b_sub = n_sub; b_bal = n_bal; b_wd = n_wd; b_ej = n_ej; b_err = n_err;
  endtask

  function automatic int pulses_since();
    return (n_sub - b_sub) + (n_bal - b_bal) + (n_wd - b_wd) + (n_ej - b_ej) + (n_err - b_err);
  endfunction

  task automatic press(input logic [3:0] code);
    KeyCode   = code;
    KeyStrobe = 1'b1;
    step(4);
    KeyStrobe = 1'b0;
    step(4);
  endtask

  int first_ej;

  initial begin
    Clear = 1'b1; CardIn = 1'b0; ErrPass = 1'b0; KeyStrobe = 1'b0; KeyCode = 4'h0;
    step(2);
    check("rst_state", int'(EntryState), 0);
    check("rst_pw", int'(Password), 0);
    check("rst_val", int'(Value), 0);
    check("rst_pulses", int'(Submit) + int'(ShowBalance) + int'(Withdraw) + int'(Eject) + int'(EntryErr), 0);
    Clear = 1'b0;
    step(1);
    snap();
    press(4'h5);
    check("nocard_key_pulses", pulses_since(), 0);
    check("nocard_key_state", int'(EntryState), 0);

    // PIN entry, last digit wins, Submit latency
    CardIn = 1'b1;
    step(1);
    check("card_in_state", int'(EntryState), 1);
    press(4'h3);
    press(4'h7);
    snap();
    KeyCode = 4'hA; KeyStrobe = 1'b1;
    step(1); check("sub_lat1", int'(Submit), 0);
    step(1); check("sub_lat2", int'(Submit), 0);
    step(1); check("sub_lat3", int'(Submit), 1);
    check("sub_pw", int'(Password), 7);
    step(1); check("sub_lat4", int'(Submit), 0);
    KeyStrobe = 1'b0;
    step(4);
    check("sub_count", n_sub - b_sub, 1);
    check("menu_state", int'(EntryState), 2);

    // Withdraw 25
    snap();
    press(4'hD); press(4'h2); press(4'h5); press(4'hA);
    check("wd_value", int'(Value), 25);
    check("wd_count", n_wd - b_wd, 1);
    check("wd_state", int'(EntryState), 2);

    // 32 over limit
    snap();
    press(4'hD); press(4'h3); press(4'h2); press(4'hA);
    check("amt32_err", n_err - b_err, 1);
    check("amt32_wd", n_wd - b_wd, 0);
    check("amt32_value", int'(Value), 25);
    check("amt32_state", int'(EntryState), 3);

    // Third digit rejected
    snap();
    press(4'hD); press(4'h4); press(4'h1);
    check("amt_2dig_err", n_err - b_err, 0);
    press(4'h9);
    check("amt_3dig_err", n_err - b_err, 1);
    press(4'hB);
    check("amt_cancel_state", int'(EntryState), 2);

    // ErrPass back to PIN, empty Enter rejected
    snap();
    ErrPass = 1'b1;
    step(1);
    ErrPass = 1'b0;
    check("errpass_state", int'(EntryState), 1);
    check("errpass_pulses", pulses_since(), 0);
    press(4'hA);
    check("pin_empty_err", n_err - b_err, 1);
    check("pin_empty_state", int'(EntryState), 1);
    press(4'h1); press(4'hA);
    check("pw_resubmit", int'(Password), 1);
    snap();
    press(4'hC);
    check("balance_count", n_bal - b_bal, 1);
    check("balance_state", int'(EntryState), 2);

    // Card pull in AMT with Acc=2
    press(4'hD); press(4'h2);
    check("pull_pre_state", int'(EntryState), 3);
    snap();
    CardIn = 1'b0;
    step(1);
    check("pull_state", int'(EntryState), 0);
    step(2);
    check("pull_ej", n_ej - b_ej, 0);
    check("pull_wd", n_wd - b_wd, 0);
    check("pull_pw_kept", int'(Password), 1);
    check("pull_val_kept", int'(Value), 25);
    CardIn = 1'b1;
    step(1);
    check("reinsert_state", int'(EntryState), 1);
    snap();
    press(4'hA);
    check("reinsert_pinhave0", n_err - b_err, 1);
    check("reinsert_no_sub", n_sub - b_sub, 0);
    snap();
    press(4'hE);
    check("eject_key", n_ej - b_ej, 1);

    // Clear mid-entry
    press(4'h4);
    snap();
    Clear = 1'b1;
    step(1);
    check("clear_state", int'(EntryState), 0);
    check("clear_pw", int'(Password), 0);
    Clear = 1'b0;
    CardIn = 1'b0;
    step(3);
    check("clear_pulses", pulses_since(), 0);

    // Timeout: Eject after the 16th edge from PIN entry
    snap();
    CardIn = 1'b1;
    first_ej = -1;
    for (int i = 1; i <= 40 && first_ej < 0; i++) begin
      step(1);
      if (Eject) begin
        first_ej = i - 1;
        check("to_state", int'(EntryState), 0);
      end
    end
    check("to_edge", first_ej, 16);
    CardIn = 1'b0;
    step(3);

    // Key at cycle 10 restarts the count
    CardIn = 1'b1;
    first_ej = -1;
    for (int i = 1; i <= 50 && first_ej < 0; i++) begin
      step(1);
      if (i == 8)  begin KeyCode = 4'hF; KeyStrobe = 1'b1; end
      if (i == 12) KeyStrobe = 1'b0;
      if (Eject) first_ej = i - 1;
    end
    check("to_restart_edge", first_ej, 26);
    CardIn = 1'b0;
    step(2);

    check("one_hot_pulses", n_multi, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
